// File: rtl/game_state_controller_pkg.sv
// Shared types and constants for the game sequencer: state encoding, playfield
// limits and the saturating three-digit BCD increment used by the score counter.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_DYING     = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    localparam logic [10:0] GROUND_Y = 11'd440;
    localparam logic [11:0] BCD_MAX  = 12'h999;

    // Ripple a +1 through three BCD digits; 999 is sticky rather than wrapping.
    function automatic logic [11:0] bcd_inc_sat(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != BCD_MAX) begin
            if (v[3:0] != 4'd9) begin
                r[3:0] = v[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (v[7:4] != 4'd9) begin
                    r[7:4] = v[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/game_state_controller_if.sv
// Bundle of renderer/bird/button inputs and display/physics outputs exchanged
// between the game sequencer (slave) and its surroundings (master).
interface game_state_controller_if;

    logic        flap_btn;
    logic        pipe_collision;
    logic        pipe_passed;
    logic [9:0]  bird_y;
    logic [4:0]  bird_h;
    logic        game_enable;
    logic        world_reset;
    logic        flap_pulse;
    logic [11:0] score_bcd;
    logic [11:0] high_score_bcd;
    logic [1:0]  state;
    logic        game_over;

    modport master (
        output flap_btn, pipe_collision, pipe_passed, bird_y, bird_h,
        input  game_enable, world_reset, flap_pulse, score_bcd, high_score_bcd,
               state, game_over
    );

    modport slave (
        input  flap_btn, pipe_collision, pipe_passed, bird_y, bird_h,
        output game_enable, world_reset, flap_pulse, score_bcd, high_score_bcd,
               state, game_over
    );

endinterface

// File: rtl/game_state_controller_bcd_counter3.sv
// Three-digit BCD up-counter with synchronous clear (priority over inc) that
// saturates at 999.
module bcd_counter3
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        inc,
    output logic [11:0] value
);

    logic [11:0] value_q;
    logic [11:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = 12'h000;
        end else if (inc) begin
            value_d = bcd_inc_sat(value_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= 12'h000;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/game_state_controller.sv
// Top-level game sequencer: turns flaps, pipe events and bird position into the
// IDLE/PLAYING/DYING/GAME_OVER flow, score keeping and world control pulses.
module game_state_controller
    import game_pkg::*;
#(
    parameter int DEATH_HOLD      = 25_000_000,
    parameter int RESTART_LOCKOUT = 12_500_000,
    parameter int CNT_W           = 25
) (
    input  logic                    clk,
    input  logic                    reset,
    game_state_controller_if.slave  bus
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(DEATH_HOLD - 1);
    localparam logic [CNT_W-1:0] LOCKOUT   = CNT_W'(RESTART_LOCKOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic             flap_q;
    logic             game_enable_q, game_enable_d;
    logic             world_reset_q, world_reset_d;
    logic             flap_pulse_q, flap_pulse_d;
    logic             game_over_q, game_over_d;
    logic [11:0]      high_score_q, high_score_d;

    logic             flap_edge;
    logic             hit;
    logic [10:0]      bottom_edge;
    logic             score_clear;
    logic             score_inc;
    logic [11:0]      score_bcd;

    // Bottom edge is summed at 11 bits so rows near 1023 cannot wrap past the ground.
    assign bottom_edge = {1'b0, bus.bird_y} + {6'b000000, bus.bird_h};
    assign hit         = bus.pipe_collision | (bottom_edge >= GROUND_Y) | (bus.bird_y == 10'd0);
    assign flap_edge   = bus.flap_btn & ~flap_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            counter_q     <= '0;
            flap_q        <= 1'b0;
            game_enable_q <= 1'b0;
            world_reset_q <= 1'b0;
            flap_pulse_q  <= 1'b0;
            game_over_q   <= 1'b0;
            high_score_q  <= 12'h000;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            flap_q        <= bus.flap_btn;
            game_enable_q <= game_enable_d;
            world_reset_q <= world_reset_d;
            flap_pulse_q  <= flap_pulse_d;
            game_over_q   <= game_over_d;
            high_score_q  <= high_score_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        case (state_q)
            ST_IDLE: begin
                if (flap_edge) begin
                    state_d = ST_PLAYING;
                end
            end
            ST_PLAYING: begin
                if (hit) begin
                    state_d   = ST_DYING;
                    counter_d = '0;
                end
            end
            ST_DYING: begin
                if (counter_q == HOLD_LAST) begin
                    state_d   = ST_GAME_OVER;
                    counter_d = '0;
                end else begin
                    counter_d = counter_q + CNT_ONE;
                end
            end
            ST_GAME_OVER: begin
                if (flap_edge && (counter_q >= LOCKOUT)) begin
                    state_d   = ST_IDLE;
                    counter_d = '0;
                end else if (counter_q < LOCKOUT) begin
                    counter_d = counter_q + CNT_ONE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                counter_d = '0;
            end
        endcase
    end

    // A hit in PLAYING swallows any flap or pipe credit arriving in the same cycle.
    always_comb begin
        flap_pulse_d  = 1'b0;
        world_reset_d = 1'b0;
        score_clear   = 1'b0;
        score_inc     = 1'b0;
        high_score_d  = high_score_q;
        case (state_q)
            ST_IDLE: begin
                if (flap_edge) begin
                    flap_pulse_d = 1'b1;
                    score_clear  = 1'b1;
                end
            end
            ST_PLAYING: begin
                if (!hit) begin
                    flap_pulse_d = flap_edge;
                    score_inc    = bus.pipe_passed;
                end
            end
            ST_DYING: begin
                if ((counter_q == HOLD_LAST) && (score_bcd > high_score_q)) begin
                    high_score_d = score_bcd;
                end
            end
            ST_GAME_OVER: begin
                if (flap_edge && (counter_q >= LOCKOUT)) begin
                    world_reset_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
        game_enable_d = (state_d == ST_PLAYING);
        game_over_d   = (state_d == ST_GAME_OVER);
    end

    bcd_counter3 u_score (
        .clk   (clk),
        .reset (reset),
        .clear (score_clear),
        .inc   (score_inc),
        .value (score_bcd)
    );

    assign bus.game_enable    = game_enable_q;
    assign bus.world_reset    = world_reset_q;
    assign bus.flap_pulse     = flap_pulse_q;
    assign bus.score_bcd      = score_bcd;
    assign bus.high_score_bcd = high_score_q;
    assign bus.state          = state_q;
    assign bus.game_over      = game_over_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Scoreboard bench for game_state_controller: directed games push expected output
// snapshots per cycle; an independent monitor pops and compares them.
module tb_game_state_controller;
    import game_pkg::*;

    localparam int DEATH_HOLD      = 8;
    localparam int RESTART_LOCKOUT = 4;
    localparam int CNT_W           = 25;

    typedef struct packed {
        logic [1:0]  state;
        logic        en;
        logic        wr;
        logic        fp;
        logic [11:0] score;
        logic [11:0] high;
        logic        go;
    } exp_t;

    logic clk;
    logic reset;

    game_state_controller_if bus_if ();

    game_state_controller #(
        .DEATH_HOLD      (DEATH_HOLD),
        .RESTART_LOCKOUT (RESTART_LOCKOUT),
        .CNT_W           (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    exp_t   exp_q[$];
    string  tag_q[$];
    int     checks = 0;
    int     errors = 0;

    state_t e_state;
    int     e_score;
    int     e_high;
    logic   e_fp;
    logic   e_wr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] toBcd(input int v);
        int h;
        int t;
        int o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        return {4'(h), 4'(t), 4'(o)};
    endfunction

    task automatic checkOutput(input string tag, input string field, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s.%s actual=%0h required=%0h at %0t", tag, field, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must show after the next edge.
    task automatic applyStimulus(input logic rst_in, input logic flap, input logic coll,
                                 input logic passed, input logic [9:0] y, input logic [4:0] h,
                                 input string tag);
        exp_t e;
        @(negedge clk);
        reset                 = rst_in;
        bus_if.flap_btn       = flap;
        bus_if.pipe_collision = coll;
        bus_if.pipe_passed    = passed;
        bus_if.bird_y         = y;
        bus_if.bird_h         = h;
        e.state = e_state;
        e.en    = (e_state == ST_PLAYING);
        e.wr    = e_wr;
        e.fp    = e_fp;
        e.score = toBcd(e_score);
        e.high  = toBcd(e_high);
        e.go    = (e_state == ST_GAME_OVER);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        e_fp = 1'b0;
        e_wr = 1'b0;
    endtask

    task automatic quiet(input string tag);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'd200, 5'd10, tag);
    endtask

    task automatic startGame();
        e_state = ST_PLAYING;
        e_fp    = 1'b1;
        e_score = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'd200, 5'd10, "flap_start");
        quiet("flap_release");
    endtask

    task automatic passPipes(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            e_score = (e_score < 999) ? e_score + 1 : 999;
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10'd200, 5'd10, "pipe_pass");
            if (gaps) quiet("pipe_gap");
        end
    endtask

    // Seven more frozen cycles with junk inputs, then GAME_OVER with high-score update.
    task automatic deathSequence();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, (i == 1 || i == 3), (i == 2), (i == 4),
                          (i == 5) ? 10'd0 : 10'd200, 5'd10, "dying_hold");
        end
        if (e_score > e_high) e_high = e_score;
        e_state = ST_GAME_OVER;
        quiet("enter_game_over");
    endtask

    task automatic lockoutAndRestart();
        quiet("lockout_c0");
        quiet("lockout_c1");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'd200, 5'd10, "lockout_flap_ignored");
        quiet("lockout_c3");
        quiet("lockout_c4");
        e_state = ST_IDLE;
        e_wr    = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'd200, 5'd10, "restart_flap");
        quiet("idle_after_restart");
    endtask

    initial begin
        exp_t  e;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checkOutput(t, "state",       int'(bus_if.state),          int'(e.state));
                checkOutput(t, "game_enable", int'(bus_if.game_enable),    int'(e.en));
                checkOutput(t, "world_reset", int'(bus_if.world_reset),    int'(e.wr));
                checkOutput(t, "flap_pulse",  int'(bus_if.flap_pulse),     int'(e.fp));
                checkOutput(t, "score",       int'(bus_if.score_bcd),      int'(e.score));
                checkOutput(t, "high_score",  int'(bus_if.high_score_bcd), int'(e.high));
                checkOutput(t, "game_over",   int'(bus_if.game_over),      int'(e.go));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset                 = 1'b1;
        bus_if.flap_btn       = 1'b0;
        bus_if.pipe_collision = 1'b0;
        bus_if.pipe_passed    = 1'b0;
        bus_if.bird_y         = 10'd200;
        bus_if.bird_h         = 5'd10;
        e_state = ST_IDLE;
        e_score = 0;
        e_high  = 0;
        e_fp    = 1'b0;
        e_wr    = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'd200, 5'd10, "reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'd200, 5'd10, "reset_hold");

        // Game A: held flap, score to saturation, ground boundary, flap swallowed by hit.
        e_state = ST_PLAYING;
        e_fp    = 1'b1;
        e_score = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'd200, 5'd10, "flap_start");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'd200, 5'd10, "flap_held1");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'd200, 5'd10, "flap_held2");
        quiet("flap_release");
        passPipes(10, 1'b1);
        passPipes(994, 1'b0);
        quiet("score_saturated");
        e_fp = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'd200, 5'd10, "play_flap");
        quiet("play_flap_release");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'd429, 5'd10, "ground_miss_439");
        e_state = ST_DYING;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'd430, 5'd10, "ground_hit_440_flap");
        deathSequence();
        lockoutAndRestart();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 5'd10, "idle_hit_ignored");

        e_state = ST_IDLE;
        e_score = 0;
        e_high  = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'd200, 5'd10, "reset_between");

        // Game B: hit and pipe credit in the same cycle at 007.
        startGame();
        passPipes(7, 1'b1);
        e_state = ST_DYING;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 10'd200, 5'd10, "hit_and_pass");
        deathSequence();
        lockoutAndRestart();

        // Game C: ceiling hit at 012 sets a new best.
        startGame();
        passPipes(12, 1'b1);
        e_state = ST_DYING;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 5'd10, "ceiling_hit");
        deathSequence();
        lockoutAndRestart();

        // Game D: lower score leaves the best untouched.
        startGame();
        passPipes(5, 1'b1);
        e_state = ST_DYING;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 10'd200, 5'd10, "pipe_hit");
        deathSequence();
        lockoutAndRestart();

        // Game E: reset mid-play wipes everything including the best.
        startGame();
        passPipes(3, 1'b1);
        e_state = ST_IDLE;
        e_score = 0;
        e_high  = 0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 10'd200, 5'd10, "reset_mid_play");
        quiet("after_reset");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
